pci_arbiter: RTL and testbench
==============================

PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on rising CLK.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: GRANT cycles allowed without FRAME low before the grant is revoked; legal range 2..255.
REQ-003 CLK  input  1  bus clock.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 REQ  input  4  per-device bus request, active low; bit i comes from the device with DeviceAddress i.
REQ-006 FRAME  input  1  bus FRAME#, active low, sampled only.
REQ-007 IRDY  input  1  bus IRDY#, active low, sampled only.
REQ-008 GNT  output  4  per-device grant, active low, registered; at most one bit low at any time.
REQ-009 OWNER  output  2  index of the device currently granted; valid only while BUS_BUSY=1.
REQ-010 BUS_BUSY  output  1  high in GRANT and BUSY states.
REQ-011 TIMEOUT  output  1  one-cycle high pulse when a grant is revoked by timeout.

Function
REQ-012 FSM states: IDLE, GRANT, BUSY, TURNAROUND; registered state; no other states reachable.
REQ-013 IDLE: all GNT high; if any REQ bit sampled low, select winner, drive GNT[winner] low, load OWNER=winner, go to GRANT on the same edge.
REQ-014 Winner selection SHALL be round-robin: search starts at (LAST+1) mod 4 and wraps; the first REQ bit found low wins.
REQ-015 LAST SHALL be updated to the winner on every grant, including grants later revoked by timeout.
REQ-016 GRANT: if FRAME sampled low, go to BUSY, GNT unchanged; FRAME has priority over all other GRANT exits in the same cycle.
REQ-017 GRANT: if FRAME high and REQ[OWNER] sampled high (request withdrawn), drive all GNT high and go to IDLE; no TIMEOUT pulse.
REQ-018 GRANT: a 8-bit counter SHALL clear on entry and increment each GRANT cycle; on reaching TIMEOUT_CYCLES with FRAME high, drive all GNT high, pulse TIMEOUT for one cycle, and go to IDLE.
REQ-019 BUSY: GNT[OWNER] SHALL stay low while FRAME low or IRDY low; when FRAME and IRDY are both sampled high, drive all GNT high and go to TURNAROUND.
REQ-020 TURNAROUND SHALL last exactly one cycle with all GNT high, then go to IDLE; REQ is ignored in this state.
REQ-021 Minimum gap between one device's GNT going high and any device's GNT going low SHALL be 2 cycles after BUSY and 1 cycle after a GRANT exit.
REQ-022 REQ changes in BUSY SHALL NOT affect GNT or OWNER.
REQ-023 A device holding REQ low continuously SHALL be regranted only after every other device that is requesting has received one grant.
REQ-024 BUS_BUSY SHALL equal 1 exactly in GRANT and BUSY and 0 in IDLE and TURNAROUND.

Reset
REQ-025 With RST high at a rising edge: GNT=4'b1111, OWNER=0, BUS_BUSY=0, TIMEOUT=0, state=IDLE, counter=0, LAST=3; device 0 therefore has first priority.
REQ-026 RST SHALL override every state, including mid-BUSY, and all GNT SHALL be high in the cycle after reset is sampled.
REQ-027 REQ, FRAME and IRDY SHALL be ignored while RST is high.

Verification
REQ-028 Reset, then REQ=4'b1110 -> next cycle GNT=4'b1110, OWNER=0, BUS_BUSY=1.
REQ-029 REQ=4'b0000 held, each device asserts FRAME 1 cycle after its grant for 3 cycles, then releases FRAME and IRDY -> grant order 0,1,2,3,0 with one TURNAROUND cycle with GNT=4'b1111 between grants.
REQ-030 Grant device 2, FRAME held high for 16 cycles -> GNT=4'b1111 and TIMEOUT=1 for exactly one cycle; with REQ=4'b0000 the next grant goes to device 3.
REQ-031 Grant device 1, then REQ[1] raised before FRAME low -> GNT=4'b1111 on the next cycle; no TIMEOUT pulse.
REQ-032 In BUSY with OWNER=3, assert RST for one cycle -> GNT=4'b1111, BUS_BUSY=0; then REQ=4'b0111 -> device 3 is granted.
REQ-033 In BUSY, raise FRAME while IRDY is still low for 2 cycles -> GNT stays low until IRDY rises, then TURNAROUND.

Source files
------------

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin bus arbiter for four PCI-style devices.
//
// Ports:
//   CLK       bus clock, all state changes on the rising edge
//   RST       synchronous active-high reset
//   REQ[3:0]  per-device bus request, active low (bit i = device i)
//   FRAME     bus FRAME#, active low, sampled only
//   IRDY      bus IRDY#, active low, sampled only
//   GNT[3:0]  per-device grant, active low, registered, at most one low
//   OWNER     index of the granted device, valid while BUS_BUSY=1
//   BUS_BUSY  high while a device holds the grant (GRANT or BUSY)
//   TIMEOUT   one-cycle pulse when an unused grant is revoked
module pci_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       FRAME,
    input  logic       IRDY,
    output logic [3:0] GNT,
    output logic [1:0] OWNER,
    output logic       BUS_BUSY,
    output logic       TIMEOUT
);

    localparam int unsigned NDEV  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_TURN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] last_n;
    logic [NDEV-1:0]  gnt_n;
    logic [IDX_W-1:0] owner_n;
    logic             busy_n;
    logic             timeout_n;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;

    assign cnt_inc = cnt + CNT_W'(1);

    // Round-robin search starting one past the last winner; k=4 wraps back to LAST itself.
    always_comb begin
        win   = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= int'(NDEV); k++) begin
            cand = last + IDX_W'(k);
            if (!found && !REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last;
        gnt_n     = GNT;
        owner_n   = OWNER;
        timeout_n = 1'b0;

        case (state)
            S_IDLE: begin
                gnt_n = '1;
                if (found) begin
                    state_n = S_GRANT;
                    gnt_n   = ~(NDEV'(1) << win);
                    owner_n = win;
                    last_n  = win;
                    cnt_n   = '0;
                end
            end
            S_GRANT: begin
                // FRAME wins over withdrawal and timeout in the same cycle.
                if (!FRAME) begin
                    state_n = S_BUSY;
                end else if (REQ[OWNER]) begin
                    state_n = S_IDLE;
                    gnt_n   = '1;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_n   = S_IDLE;
                    gnt_n     = '1;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_BUSY: begin
                // Transfer ends only when both FRAME# and IRDY# are deasserted.
                if (FRAME && IRDY) begin
                    state_n = S_TURN;
                    gnt_n   = '1;
                end
            end
            S_TURN: begin
                state_n = S_IDLE;
                gnt_n   = '1;
            end
            default: begin
                state_n = S_IDLE;
                gnt_n   = '1;
            end
        endcase

        busy_n = (state_n == S_GRANT) || (state_n == S_BUSY);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= IDX_W'(NDEV - 1);
            GNT      <= '1;
            OWNER    <= '0;
            BUS_BUSY <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last     <= last_n;
            GNT      <= gnt_n;
            OWNER    <= owner_n;
            BUS_BUSY <= busy_n;
            TIMEOUT  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed scenarios plus random traffic for pci_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_pci_arbiter;

    localparam int unsigned TO_CYC = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = 4'hF;
    logic       FRAME = 1'b1;
    logic       IRDY = 1'b1;
    logic [3:0] GNT;
    logic [1:0] OWNER;
    logic       BUS_BUSY;
    logic       TIMEOUT;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: who holds the bus, whether a transfer started,
    // cooldown cycles before a new grant, cycles spent waiting for FRAME.
    int m_dev   = -1;
    bit m_tx    = 1'b0;
    int m_hold  = 0;
    int m_age   = 0;
    int m_last  = 3;
    int m_owner = 0;
    bit m_to    = 1'b0;

    pci_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .FRAME    (FRAME),
        .IRDY     (IRDY),
        .GNT      (GNT),
        .OWNER    (OWNER),
        .BUS_BUSY (BUS_BUSY),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        m_to = 1'b0;
        if (RST) begin
            m_dev = -1; m_tx = 1'b0; m_hold = 0; m_age = 0; m_last = 3; m_owner = 0;
        end else if (m_dev < 0) begin
            if (m_hold > 0) begin
                m_hold--;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int d;
                    d = (m_last + k) % 4;
                    if (m_dev < 0 && REQ[d] == 1'b0) begin
                        m_dev = d; m_owner = d; m_last = d; m_age = 0; m_tx = 1'b0;
                    end
                end
            end
        end else if (!m_tx) begin
            if (!FRAME) begin
                m_tx = 1'b1;
            end else if (REQ[m_dev]) begin
                m_dev = -1;
            end else begin
                m_age++;
                if (m_age == int'(TO_CYC)) begin
                    m_dev = -1;
                    m_to  = 1'b1;
                end
            end
        end else if (FRAME && IRDY) begin
            m_dev  = -1;
            m_hold = 1;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        eg = (m_dev < 0) ? 4'hF : ~(4'b0001 << m_dev);
        chk("gnt", 32'(GNT), 32'(eg));
        chk("bus_busy", 32'(BUS_BUSY), 32'(m_dev >= 0));
        chk("timeout", 32'(TIMEOUT), 32'(m_to));
        if (m_dev >= 0) chk("owner", 32'(OWNER), 32'(m_owner));
        chk("gnt_onehot", 32'($countones(~GNT) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic wait_grant(output int dev);
        dev = -1;
        for (int i = 0; i < 20 && dev < 0; i++) begin
            step();
            for (int j = 0; j < 4; j++) if (!GNT[j]) dev = j;
        end
        if (dev < 0) chk("grant_wait", 32'(GNT), 32'hE);
    endtask

    initial begin
        int d;
        int cyc;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        step(); step();
        chk("rst_gnt", 32'(GNT), 32'hF);
        chk("rst_busy", 32'(BUS_BUSY), 32'd0);
        chk("rst_owner", 32'(OWNER), 32'd0);
        chk("rst_timeout", 32'(TIMEOUT), 32'd0);

        // Single request from device 0
        RST = 1'b0; REQ = 4'b1110;
        step();
        chk("first_gnt", 32'(GNT), 32'hE);
        chk("first_owner", 32'(OWNER), 32'd0);
        chk("first_busy", 32'(BUS_BUSY), 32'd1);
        REQ = 4'hF;
        step();
        chk("withdraw0_gnt", 32'(GNT), 32'hF);

        // Round-robin with all requesting, full transfers
        RST = 1'b1; step(); RST = 1'b0;
        REQ = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            wait_grant(d);
            chk("rr_order", 32'(d), 32'(exp_order[n]));
            FRAME = 1'b0; IRDY = 1'b0;
            step(); step(); step();
            FRAME = 1'b1; IRDY = 1'b1;
            step();
            chk("rr_turnaround", 32'(GNT), 32'hF);
        end
        REQ = 4'hF;

        // FRAME released while IRDY still low keeps the grant
        REQ = 4'b1101;
        wait_grant(d);
        chk("irdy_dev", 32'(d), 32'd1);
        FRAME = 1'b0; IRDY = 1'b0;
        step();
        FRAME = 1'b1;
        step(); chk("irdy_hold1", 32'(GNT), 32'hD);
        step(); chk("irdy_hold2", 32'(GNT), 32'hD);
        IRDY = 1'b1;
        step(); chk("irdy_release", 32'(GNT), 32'hF);

        // Request withdrawn before FRAME
        wait_grant(d);
        chk("withdraw_dev", 32'(d), 32'd1);
        REQ = 4'hF;
        step();
        chk("withdraw_gnt", 32'(GNT), 32'hF);
        chk("withdraw_no_to", 32'(TIMEOUT), 32'd0);

        // Timeout on device 2, then device 3 next
        REQ = 4'b1011;
        wait_grant(d);
        chk("to_dev", 32'(d), 32'd2);
        cyc = 0;
        for (int i = 0; i < 40 && GNT != 4'hF; i++) begin
            step();
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 32'(TO_CYC));
        chk("to_pulse", 32'(TIMEOUT), 32'd1);
        REQ = 4'b0000;
        step();
        chk("to_pulse_end", 32'(TIMEOUT), 32'd0);
        chk("after_to_gnt", 32'(GNT), 32'h7);

        // Reset in BUSY with owner 3
        FRAME = 1'b0;
        step();
        chk("busy3", 32'(BUS_BUSY), 32'd1);
        RST = 1'b1;
        step();
        chk("midrst_gnt", 32'(GNT), 32'hF);
        chk("midrst_busy", 32'(BUS_BUSY), 32'd0);
        RST = 1'b0; FRAME = 1'b1; REQ = 4'b0111;
        step();
        chk("post_rst_gnt", 32'(GNT), 32'h7);
        REQ = 4'hF;
        step(); step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            REQ   = 4'($urandom);
            FRAME = ($urandom_range(0, 3) != 0);
            IRDY  = ($urandom_range(0, 1) != 0);
            RST   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
